// File: rtl/multicycle_control_unit_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// master = controller side (drives controls), slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int STATE_W    = 4,
    parameter int ALU_CTRL_W = 3
);
    logic [31:0]           Instr;
    logic                  zero;
    logic                  mem_ready;
    logic                  MemtoReg;
    logic                  RegDst;
    logic                  IorD;
    logic                  ALUSrcA;
    logic                  IRWrite;
    logic                  MemWrite;
    logic                  PCWrite;
    logic                  Branch;
    logic                  RegWrite;
    logic                  PCEn;
    logic [1:0]            PCSrc;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALU_Control;
    logic                  illegal;
    logic [STATE_W-1:0]    state;

    modport master (
        input  Instr, zero, mem_ready,
        output MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
               Branch, RegWrite, PCEn, PCSrc, ALUSrcB, ALU_Control, illegal, state
    );

    modport slave (
        output Instr, zero, mem_ready,
        input  MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
               Branch, RegWrite, PCEn, PCSrc, ALUSrcB, ALU_Control, illegal, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: Moore FSM with memory-ready stalls plus ALU decode.
// Optional macro MCU_BNE_EN adds a bne branch state (BRNE, encoding 12).
module multicycle_control_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 4,
    parameter int ALU_CTRL_W    = 3
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.master ctrl_if
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        BRNE     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCU_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t     state_q, state_d;
    logic       rdy;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
    logic       instr_unused;

    logic       mem_to_reg, reg_dst, iord, alu_src_a, ir_write, mem_write;
    logic       pc_write, branch, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b;

    assign rdy          = MEM_HANDSHAKE ? ctrl_if.mem_ready : 1'b1;
    assign opcode       = ctrl_if.Instr[31:26];
    assign funct        = ctrl_if.Instr[5:0];
    assign instr_unused = ^ctrl_if.Instr[25:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                state_d   = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
`ifdef MCU_BNE_EN
                    OP_BNE:       state_d = BRNE;
`endif
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            // MemWrite stays high for the whole stall so slow memories see a stable request
            MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = rdy ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
`ifdef MCU_BNE_EN
            BRNE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
`endif
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                alu_src_b = 2'b01;
            end
        endcase
        // Async reset already holds state at FETCH; this also kills FETCH's rdy-driven writes
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    always_comb begin
        alu_ctrl = 3'b010;
        case (alu_op)
            2'b00: alu_ctrl = 3'b010;
            2'b01: alu_ctrl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alu_ctrl = 3'b010;
                    6'b100010: alu_ctrl = 3'b110;
                    6'b100100: alu_ctrl = 3'b000;
                    6'b100101: alu_ctrl = 3'b001;
                    6'b101010: alu_ctrl = 3'b111;
                    default:   alu_ctrl = 3'b010;
                endcase
            end
            default: alu_ctrl = 3'b010;
        endcase
    end

`ifdef MCU_BNE_EN
    logic bne;
    assign bne          = (state_q == BRNE);
    assign ctrl_if.PCEn = pc_write | (branch & (ctrl_if.zero ^ bne));
`else
    assign ctrl_if.PCEn = pc_write | (branch & ctrl_if.zero);
`endif

    assign ctrl_if.MemtoReg    = mem_to_reg;
    assign ctrl_if.RegDst      = reg_dst;
    assign ctrl_if.IorD        = iord;
    assign ctrl_if.ALUSrcA     = alu_src_a;
    assign ctrl_if.IRWrite     = ir_write;
    assign ctrl_if.MemWrite    = mem_write;
    assign ctrl_if.PCWrite     = pc_write;
    assign ctrl_if.Branch      = branch;
    assign ctrl_if.RegWrite    = reg_write;
    assign ctrl_if.PCSrc       = pc_src;
    assign ctrl_if.ALUSrcB     = alu_src_b;
    assign ctrl_if.ALU_Control = ALU_CTRL_W'(alu_ctrl);
    assign ctrl_if.illegal     = illegal;
    assign ctrl_if.state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expectations queued per cycle, popped on the falling edge.
module tb_multicycle_control_unit;

  localparam logic [31:0] I_LW     = 32'h8C080004;
  localparam logic [31:0] I_SW     = 32'hAC080004;
  localparam logic [31:0] I_SLT    = 32'h0109402A;
  localparam logic [31:0] I_BADFN  = 32'h0109403F;
  localparam logic [31:0] I_SUB    = 32'h01094022;
  localparam logic [31:0] I_BEQ    = 32'h11090003;
  localparam logic [31:0] I_ADDI   = 32'h21090005;
  localparam logic [31:0] I_J      = 32'h08000010;
  localparam logic [31:0] I_BNE    = 32'h15090003;
  localparam logic [31:0] I_BADOP  = 32'hFC000000;

  localparam int S_STATE = 0,  S_IRW = 1,  S_PCW = 2,   S_PCEN = 3,  S_MEMW = 4;
  localparam int S_REGW  = 5,  S_MTR = 6,  S_ALU = 7,   S_ILL = 8,   S_IORD = 9;
  localparam int S_RDST  = 10, S_PCSRC = 11, S_SRCB = 12;
  localparam int S2_STATE = 20, S2_MEMW = 21;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cnum = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.STATE_W(4), .ALU_CTRL_W(3)) bus1 ();
  multicycle_control_unit_if #(.STATE_W(4), .ALU_CTRL_W(3)) bus2 ();

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .STATE_W(4), .ALU_CTRL_W(3)) u_dut (
    .clk(clk), .rst(rst), .ctrl_if(bus1)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .STATE_W(4), .ALU_CTRL_W(3)) u_dut_nohs (
    .clk(clk), .rst(rst), .ctrl_if(bus2)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int obs(input int sel);
    case (sel)
      S_STATE:  return int'(bus1.state);
      S_IRW:    return int'(bus1.IRWrite);
      S_PCW:    return int'(bus1.PCWrite);
      S_PCEN:   return int'(bus1.PCEn);
      S_MEMW:   return int'(bus1.MemWrite);
      S_REGW:   return int'(bus1.RegWrite);
      S_MTR:    return int'(bus1.MemtoReg);
      S_ALU:    return int'(bus1.ALU_Control);
      S_ILL:    return int'(bus1.illegal);
      S_IORD:   return int'(bus1.IorD);
      S_RDST:   return int'(bus1.RegDst);
      S_PCSRC:  return int'(bus1.PCSrc);
      S_SRCB:   return int'(bus1.ALUSrcB);
      S2_STATE: return int'(bus2.state);
      S2_MEMW:  return int'(bus2.MemWrite);
      default:  return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cnum) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  end

  task automatic ex(input string tag, input int sel, input int val);
    sb.push_back('{cnum, tag, sel, val});
  endtask

  task automatic drive(input logic [31:0] instr, input logic mr, input logic z);
    bus1.Instr = instr; bus1.mem_ready = mr; bus1.zero = z;
    bus2.Instr = instr; bus2.mem_ready = mr; bus2.zero = z;
  endtask

  task automatic step(input logic [31:0] instr, input logic mr, input logic z);
    @(posedge clk);
    #1;
    cnum++;
    drive(instr, mr, z);
  endtask

  // FETCH and DECODE cycles with rdy high; checks state 0 then 1
  task automatic fd(input string nm, input logic [31:0] instr);
    step(instr, 1'b1, 1'b0);
    ex({nm, "_fetch"}, S_STATE, 0);
    ex({nm, "_irw"}, S_IRW, 1);
    step(instr, 1'b1, 1'b0);
    ex({nm, "_decode"}, S_STATE, 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(I_LW, 1'b1, 1'b0);

    // reset holds FETCH and suppresses writes even with mem_ready high
    step(I_LW, 1'b1, 1'b0);
    ex("rst_state", S_STATE, 0); ex("rst_irw", S_IRW, 0); ex("rst_pcw", S_PCW, 0);
    ex("rst_pcen", S_PCEN, 0);   ex("rst_srcb", S_SRCB, 1); ex("rst_regw", S_REGW, 0);

    // lw: 0,1,2,3,4
    step(I_LW, 1'b1, 1'b0);
    rst = 1'b0;
    ex("lw_s0", S_STATE, 0); ex("lw_irw", S_IRW, 1); ex("lw_pcw", S_PCW, 1);
    ex("lw_pcen", S_PCEN, 1); ex("lw_regw0", S_REGW, 0);
    step(I_LW, 1'b1, 1'b0);
    ex("lw_s1", S_STATE, 1); ex("lw_srcb1", S_SRCB, 3); ex("lw_regw1", S_REGW, 0);
    step(I_LW, 1'b1, 1'b0);
    ex("lw_s2", S_STATE, 2); ex("lw_srcb2", S_SRCB, 2); ex("lw_alu2", S_ALU, 2);
    step(I_LW, 1'b1, 1'b0);
    ex("lw_s3", S_STATE, 3); ex("lw_iord", S_IORD, 1); ex("lw_regw3", S_REGW, 0);
    step(I_LW, 1'b1, 1'b0);
    ex("lw_s4", S_STATE, 4); ex("lw_regw4", S_REGW, 1); ex("lw_mtr4", S_MTR, 1);

    // FETCH stall, then sw to MEMWRITE, then reset during the MEMWRITE wait
    step(I_SW, 1'b0, 1'b0);
    ex("fstall_state", S_STATE, 0); ex("fstall_irw", S_IRW, 0); ex("fstall_pcen", S_PCEN, 0);
    fd("sw_a", I_SW);
    step(I_SW, 1'b1, 1'b0);
    ex("sw_a_s2", S_STATE, 2);
    step(I_SW, 1'b0, 1'b0);
    ex("sw_a_s5", S_STATE, 5); ex("sw_a_memw", S_MEMW, 1);
    step(I_SW, 1'b0, 1'b0);
    rst = 1'b1;
    ex("rstmid_state", S_STATE, 0); ex("rstmid_memw", S_MEMW, 0); ex("rstmid_mtr", S_MTR, 0);
    step(I_SW, 1'b1, 1'b0);
    rst = 1'b0;
    ex("rstrel_irw", S_IRW, 1); ex("rstrel_pcw", S_PCW, 1);

    // sw with 3 stall cycles: handshaking DUT holds MemWrite 4 cycles, the other 1
    ex("sw_b_s0", S_STATE, 0); ex("sw_b_nohs_s0", S2_STATE, 0);
    step(I_SW, 1'b1, 1'b0);
    ex("sw_b_s1", S_STATE, 1); ex("sw_b_nohs_s1", S2_STATE, 1);
    step(I_SW, 1'b1, 1'b0);
    ex("sw_b_s2", S_STATE, 2); ex("sw_b_nohs_s2", S2_STATE, 2); ex("sw_b_memw2", S_MEMW, 0);
    step(I_SW, 1'b0, 1'b0);
    ex("sw_b_w1", S_MEMW, 1); ex("sw_b_nohs_w1", S2_MEMW, 1); ex("sw_b_nohs_s5", S2_STATE, 5);
    step(I_SW, 1'b0, 1'b0);
    ex("sw_b_w2", S_MEMW, 1); ex("sw_b_nohs_w2", S2_MEMW, 0); ex("sw_b_nohs_back", S2_STATE, 0);
    step(I_SW, 1'b0, 1'b0);
    ex("sw_b_w3", S_MEMW, 1); ex("sw_b_w3_s", S_STATE, 5);
    step(I_SW, 1'b1, 1'b0);
    ex("sw_b_w4", S_MEMW, 1); ex("sw_b_w4_iord", S_IORD, 1);

    // R-type slt, unknown funct, sub
    fd("slt", I_SLT);
    ex("slt_dec_memw", S_MEMW, 0);
    step(I_SLT, 1'b1, 1'b0);
    ex("slt_s6", S_STATE, 6); ex("slt_alu", S_ALU, 7);
    step(I_SLT, 1'b1, 1'b0);
    ex("slt_s7", S_STATE, 7); ex("slt_rdst", S_RDST, 1); ex("slt_regw", S_REGW, 1);
    fd("badfn", I_BADFN);
    step(I_BADFN, 1'b1, 1'b0);
    ex("badfn_s6", S_STATE, 6); ex("badfn_alu", S_ALU, 2);
    step(I_BADFN, 1'b1, 1'b0);
    fd("sub", I_SUB);
    ex("sub_fetchalu", S_ALU, 2);
    step(I_SUB, 1'b1, 1'b0);
    ex("sub_alu", S_ALU, 6);
    step(I_SUB, 1'b1, 1'b0);

    // beq taken / not taken
    fd("beq_t", I_BEQ);
    step(I_BEQ, 1'b1, 1'b1);
    ex("beq_t_s8", S_STATE, 8); ex("beq_t_pcen", S_PCEN, 1); ex("beq_t_pcsrc", S_PCSRC, 1);
    ex("beq_t_alu", S_ALU, 6); ex("beq_t_pcw", S_PCW, 0);
    fd("beq_n", I_BEQ);
    step(I_BEQ, 1'b1, 1'b0);
    ex("beq_n_s8", S_STATE, 8); ex("beq_n_pcen", S_PCEN, 0);

    // addi, j
    fd("addi", I_ADDI);
    step(I_ADDI, 1'b1, 1'b0);
    ex("addi_s9", S_STATE, 9); ex("addi_srcb", S_SRCB, 2);
    step(I_ADDI, 1'b1, 1'b0);
    ex("addi_s10", S_STATE, 10); ex("addi_regw", S_REGW, 1); ex("addi_rdst", S_RDST, 0);
    fd("j", I_J);
    step(I_J, 1'b1, 1'b0);
    ex("j_s11", S_STATE, 11); ex("j_pcw", S_PCW, 1); ex("j_pcen", S_PCEN, 1); ex("j_pcsrc", S_PCSRC, 2);

    // bne
    fd("bne", I_BNE);
`ifdef MCU_BNE_EN
    ex("bne_dec_ill", S_ILL, 0);
    step(I_BNE, 1'b1, 1'b0);
    ex("bne_s12", S_STATE, 12); ex("bne_pcen", S_PCEN, 1);
`else
    ex("bne_dec_ill", S_ILL, 1);
    step(I_BNE, 1'b1, 1'b0);
    ex("bne_back", S_STATE, 0); ex("bne_ill_off", S_ILL, 0);
    step(I_BNE, 1'b1, 1'b0);
`endif

    // unknown opcode pulses illegal for one cycle
    fd("badop", I_BADOP);
    ex("badop_ill", S_ILL, 1);
    step(I_BADOP, 1'b1, 1'b0);
    ex("badop_back", S_STATE, 0); ex("badop_ill_off", S_ILL, 0); ex("badop_irw", S_IRW, 1);

    @(negedge clk);
    #1;
    check_eq("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
